// File: rtl/scfifo_flex_if.sv
// Handshake and status bundle for scfifo_flex. The master drives requests and
// write data. The slave is the FIFO, which drives read data and status.
interface scfifo_flex_if #(
    parameter int unsigned WIDTH     = 20,
    parameter int unsigned LOG_DEPTH = 5
);
    logic               wrreq;
    logic [WIDTH-1:0]   data;
    logic               rdreq;
    logic               err_clr;
    logic [WIDTH-1:0]   q;
    logic               empty;
    logic               full;
    logic               almost_empty;
    logic               almost_full;
    logic [LOG_DEPTH:0] usedw;
    logic               overflow;
    logic               underflow;

    modport master (
        output wrreq, data, rdreq, err_clr,
        input  q, empty, full, almost_empty, almost_full, usedw, overflow, underflow
    );

    modport slave (
        input  wrreq, data, rdreq, err_clr,
        output q, empty, full, almost_empty, almost_full, usedw, overflow, underflow
    );
endinterface

// File: rtl/scfifo_flex.sv
// Single-clock FIFO. All 2**LOG_DEPTH words are usable.
// The read mode is either normal or show-ahead.
// The status flags are registered, and the overflow/underflow error flags are sticky.
module scfifo_flex #(
    parameter int unsigned WIDTH              = 20,
    parameter int unsigned LOG_DEPTH          = 5,
    parameter int unsigned ALMOST_FULL_VALUE  = 30,
    parameter int unsigned ALMOST_EMPTY_VALUE = 2,
    parameter bit          SHOW_AHEAD         = 1'b0,
    parameter bit          OVERFLOW_CHECKING  = 1'b1,
    parameter bit          UNDERFLOW_CHECKING = 1'b1
) (
    input logic         clock,
    input logic         sclr,
    scfifo_flex_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] UsedMax = DEPTH[LOG_DEPTH:0];
    localparam logic [LOG_DEPTH:0] AfVal   = ALMOST_FULL_VALUE[LOG_DEPTH:0];
    localparam logic [LOG_DEPTH:0] AeVal   = ALMOST_EMPTY_VALUE[LOG_DEPTH:0];

    // Show-ahead output stage: does the q register hold the head word?
    typedef enum logic {StEmpty, StValid} out_st_e;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [LOG_DEPTH:0]   usedw_q, usedw_d;
    logic [WIDTH-1:0]     q_q;
    logic                 empty_q, full_q, aempty_q, afull_q, ovf_q, unf_q;
    out_st_e              out_st_q;

    logic               wr_acc;   // write enters the FIFO this edge
    logic               pop;      // word leaves the FIFO this edge
    logic               ram_rd;   // RAM head moves into q this edge
    logic               valid_d;
    logic [LOG_DEPTH:0] valid_w;

    // Accept/reject decisions use only registered flags; the occupancy counter next state
    always_comb begin
        wr_acc  = bus.wrreq & (~full_q | ~OVERFLOW_CHECKING);
        valid_w = {{LOG_DEPTH{1'b0}}, out_st_q == StValid};
        pop     = 1'b0;
        ram_rd  = 1'b0;
        valid_d = 1'b0;
        if (SHOW_AHEAD) begin
            pop     = bus.rdreq & ((out_st_q == StValid) | ~UNDERFLOW_CHECKING);
            // RAM words = usedw minus the word parked in q; refill whenever q is free
            ram_rd  = (usedw_q > valid_w) & ((out_st_q == StEmpty) | pop);
            valid_d = ram_rd | ((out_st_q == StValid) & ~pop);
        end else begin
            pop    = bus.rdreq & (~empty_q | ~UNDERFLOW_CHECKING);
            ram_rd = pop;
        end
        unique case ({wr_acc, pop})
            2'b10:   usedw_d = usedw_q + (LOG_DEPTH + 1)'(1);
            2'b01:   usedw_d = usedw_q - (LOG_DEPTH + 1)'(1);
            default: usedw_d = usedw_q;
        endcase
    end

    // Storage array; a write at the same edge as sclr is discarded
    always_ff @(posedge clock) begin
        if (wr_acc && !sclr) begin
            mem[wr_ptr_q] <= bus.data;
        end
    end

    // Pointers, output register, output-stage FSM, registered flags and sticky errors
    always_ff @(posedge clock) begin
        if (sclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
            q_q      <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            out_st_q <= StEmpty;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + LOG_DEPTH'(1);
            end
            // The read address never equals the write address here, so no bypass is needed
            if (ram_rd) begin
                rd_ptr_q <= rd_ptr_q + LOG_DEPTH'(1);
                q_q      <= mem[rd_ptr_q];
            end
            usedw_q  <= usedw_d;
            empty_q  <= SHOW_AHEAD ? ~valid_d : (usedw_d == '0);
            full_q   <= usedw_d == UsedMax;
            aempty_q <= usedw_d < AeVal;
            afull_q  <= usedw_d >= AfVal;
            out_st_q <= valid_d ? StValid : StEmpty;
            // A violation in the same cycle as err_clr keeps the flag set
            ovf_q    <= OVERFLOW_CHECKING & ((bus.wrreq & full_q) | (ovf_q & ~bus.err_clr));
            unf_q    <= UNDERFLOW_CHECKING & ((bus.rdreq & empty_q) | (unf_q & ~bus.err_clr));
        end
    end

    assign bus.q            = q_q;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_empty = aempty_q;
    assign bus.almost_full  = afull_q;
    assign bus.usedw        = usedw_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_scfifo_flex.sv
// Bench for scfifo_flex. A normal-mode instance and a show-ahead instance share
// the same stimulus. Queue-based models predict both instances every cycle.
module tb_scfifo_flex;
    localparam int DEPTH = 32;

    logic        clk;
    logic        sclr, wrreq, rdreq, err_clr;
    logic [19:0] data;

    int n_pass  = 0;
    int n_total = 0;
    int edge_n  = 0;
    int wr_total = 0;
    bit cmp_en  = 0;

    // Normal-mode model: stored words, last read word, sticky flags
    logic [19:0] nq[$];
    logic [19:0] n_q;
    bit          n_ovf, n_unf;
    // Show-ahead model: stored words with the edge index at which each was written.
    // The head word is visible after edge e iff it was written before edge e.
    logic [19:0] sq[$];
    int          sts[$];
    bit          s_ovf, s_unf;

    scfifo_flex_if #(.WIDTH(20), .LOG_DEPTH(5)) ifn ();
    scfifo_flex_if #(.WIDTH(20), .LOG_DEPTH(5)) ifs ();

    assign ifn.wrreq   = wrreq;
    assign ifn.data    = data;
    assign ifn.rdreq   = rdreq;
    assign ifn.err_clr = err_clr;
    assign ifs.wrreq   = wrreq;
    assign ifs.data    = data;
    assign ifs.rdreq   = rdreq;
    assign ifs.err_clr = err_clr;

    scfifo_flex #(
        .WIDTH(20), .LOG_DEPTH(5), .ALMOST_FULL_VALUE(30), .ALMOST_EMPTY_VALUE(2),
        .SHOW_AHEAD(1'b0), .OVERFLOW_CHECKING(1'b1), .UNDERFLOW_CHECKING(1'b1)
    ) dut_n (.clock(clk), .sclr(sclr), .bus(ifn));

    scfifo_flex #(
        .WIDTH(20), .LOG_DEPTH(5), .ALMOST_FULL_VALUE(30), .ALMOST_EMPTY_VALUE(2),
        .SHOW_AHEAD(1'b1), .OVERFLOW_CHECKING(1'b1), .UNDERFLOW_CHECKING(1'b1)
    ) dut_s (.clock(clk), .sclr(sclr), .bus(ifs));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // Models advance on every rising edge from the inputs and their own pre-edge state
    initial forever begin
        @(posedge clk);
        edge_n++;
        if (sclr) begin
            nq.delete(); n_q = '0; n_ovf = 0; n_unf = 0;
            sq.delete(); sts.delete(); s_ovf = 0; s_unf = 0;
        end else begin
            bit nfull, nempty, sfull, svis;
            nfull  = nq.size() == DEPTH;
            nempty = nq.size() == 0;
            n_ovf  = (wrreq && nfull) || (n_ovf && !err_clr);
            n_unf  = (rdreq && nempty) || (n_unf && !err_clr);
            if (rdreq && !nempty) n_q = nq.pop_front();
            if (wrreq && !nfull) begin
                nq.push_back(data);
                wr_total++;
            end
            sfull = sq.size() == DEPTH;
            svis  = sq.size() > 0 && sts[0] < edge_n - 1;
            s_ovf = (wrreq && sfull) || (s_ovf && !err_clr);
            s_unf = (rdreq && !svis) || (s_unf && !err_clr);
            if (rdreq && svis) begin
                void'(sq.pop_front());
                void'(sts.pop_front());
            end
            if (wrreq && !sfull) begin
                sq.push_back(data);
                sts.push_back(edge_n);
            end
        end
    end

    // Compare process: mid-cycle check of both instances against the models
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            int  ns, ss;
            bit  s_empty;
            ns = nq.size();
            ss = sq.size();
            s_empty = (ss == 0) || (sts[0] >= edge_n);
            chk("n_usedw", ifn.usedw, ns);
            chk("n_empty", ifn.empty, ns == 0);
            chk("n_full", ifn.full, ns == DEPTH);
            chk("n_almost_empty", ifn.almost_empty, ns < 2);
            chk("n_almost_full", ifn.almost_full, ns >= 30);
            chk("n_overflow", ifn.overflow, n_ovf);
            chk("n_underflow", ifn.underflow, n_unf);
            chk("n_q", ifn.q, n_q);
            chk("s_usedw", ifs.usedw, ss);
            chk("s_empty", ifs.empty, s_empty);
            chk("s_full", ifs.full, ss == DEPTH);
            chk("s_almost_empty", ifs.almost_empty, ss < 2);
            chk("s_almost_full", ifs.almost_full, ss >= 30);
            chk("s_overflow", ifs.overflow, s_ovf);
            chk("s_underflow", ifs.underflow, s_unf);
            if (!s_empty) chk("s_q", ifs.q, sq[0]);
        end
    end

    task automatic drive(input bit w, input logic [19:0] d, input bit r, input bit c, input bit s);
        wrreq = w; data = d; rdreq = r; err_clr = c; sclr = s;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rst_n_usedw"}, ifn.usedw, 0);
        chk({tag, "_rst_n_empty"}, ifn.empty, 1);
        chk({tag, "_rst_n_full"}, ifn.full, 0);
        chk({tag, "_rst_n_aempty"}, ifn.almost_empty, 1);
        chk({tag, "_rst_n_afull"}, ifn.almost_full, 0);
        chk({tag, "_rst_n_ovf"}, ifn.overflow, 0);
        chk({tag, "_rst_n_unf"}, ifn.underflow, 0);
        chk({tag, "_rst_n_q"}, ifn.q, 0);
        chk({tag, "_rst_s_usedw"}, ifs.usedw, 0);
        chk({tag, "_rst_s_empty"}, ifs.empty, 1);
        chk({tag, "_rst_s_q"}, ifs.q, 0);
    endtask

    initial begin
        sclr = 1'b1; wrreq = 1'b0; rdreq = 1'b0; err_clr = 1'b0; data = '0;
        // Reset and fill to full, then one write too many
        drive(0, 0, 0, 0, 1);
        cmp_en = 1;
        chk_reset_state("t1");
        for (int i = 0; i < 32; i++) begin
            drive(1, 20'(i), 0, 0, 0);
            if (i == 0) begin
                chk("t1_n_empty_first", ifn.empty, 0);
                chk("t1_s_empty_first", ifs.empty, 1);
                chk("t1_s_usedw_first", ifs.usedw, 1);
            end
            if (i == 1) chk("t1_aempty_at2", ifn.almost_empty, 0);
            if (i == 28) chk("t1_afull_at29", ifn.almost_full, 0);
            if (i == 29) chk("t1_afull_at30", ifn.almost_full, 1);
            if (i == 30) chk("t1_full_at31", ifn.full, 0);
        end
        chk("t1_full_at32", ifn.full, 1);
        chk("t1_usedw_at32", ifn.usedw, 32);
        drive(1, 20'hFFFFF, 0, 0, 0);
        chk("t1_overflow", ifn.overflow, 1);
        chk("t1_usedw_after_ovf", ifn.usedw, 32);

        // Drain in normal mode, then underflow and error clearing
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 1, 0, 0);
            chk("t2_q", ifn.q, i);
            if (i == 30) chk("t2_empty_at1", ifn.empty, 0);
        end
        chk("t2_empty_last", ifn.empty, 1);
        chk("t2_ovf_sticky", ifn.overflow, 1);
        drive(0, 0, 1, 0, 0);
        chk("t2_underflow", ifn.underflow, 1);
        chk("t2_q_hold", ifn.q, 31);
        drive(0, 0, 1, 1, 0);
        chk("t2_unf_violation_wins", ifn.underflow, 1);
        chk("t2_ovf_cleared", ifn.overflow, 0);
        drive(0, 0, 0, 1, 0);
        chk("t2_unf_cleared", ifn.underflow, 0);

        // Simultaneous write and read at full: read accepted, write dropped
        for (int i = 0; i < 32; i++) drive(1, 20'(100 + i), 0, 0, 0);
        drive(1, 20'h55555, 1, 0, 0);
        chk("t3_overflow", ifn.overflow, 1);
        chk("t3_n_usedw", ifn.usedw, 31);
        chk("t3_n_q", ifn.q, 100);
        chk("t3_s_usedw", ifs.usedw, 31);
        drive(0, 0, 0, 1, 0);

        // Show-ahead latency and bubble-free refill
        drive(0, 0, 0, 0, 1);
        drive(1, 20'hABCDE, 0, 0, 0);
        chk("t4_s_empty_k", ifs.empty, 1);
        drive(0, 0, 0, 0, 0);
        chk("t4_s_empty_k1", ifs.empty, 0);
        chk("t4_s_q_k1", ifs.q, 20'hABCDE);
        drive(1, 20'h00001, 0, 0, 0);
        chk("t4_s_usedw2", ifs.usedw, 2);
        drive(0, 0, 1, 0, 0);
        chk("t4_s_q_refill", ifs.q, 20'h00001);
        chk("t4_s_empty_refill", ifs.empty, 0);
        drive(0, 0, 1, 0, 0);
        chk("t4_s_empty_end", ifs.empty, 1);
        chk("t4_s_usedw_end", ifs.usedw, 0);

        // sclr dominates simultaneous write/read/err_clr mid-operation
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 17; i++) drive(1, 20'(i + 7), 0, 0, 0);
        chk("t6_usedw17", ifn.usedw, 17);
        drive(1, 20'h12345, 1, 1, 1);
        chk_reset_state("t6");
        drive(0, 0, 0, 0, 0);
        chk("t6_n_no_write", ifn.usedw, 0);
        chk("t6_s_no_write", ifs.empty, 1);

        // Randomised traffic in biased phases so both full and empty are visited
        wr_total = 0;
        for (int c = 0; c < 6000; c++) begin
            int pw, pr;
            unique case ((c / 250) % 3)
                0:       begin pw = 75; pr = 75; end
                1:       begin pw = 90; pr = 50; end
                default: begin pw = 50; pr = 90; end
            endcase
            drive($urandom_range(99) < pw, 20'($urandom), $urandom_range(99) < pr,
                  $urandom_range(99) < 3, $urandom_range(999) == 0);
        end
        chk("t5_pointer_wraps_gt50", wr_total > 51 * DEPTH, 1);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
